// File: rtl/decoder_pkg.sv
// Shared widths and types for the registered 4-to-16 one-hot decoder.
package decoder_pkg;

    localparam int DEC_IN_W  = 4;
    localparam int DEC_OUT_W = 16;

    typedef logic [DEC_IN_W-1:0]  dec_sel_t;
    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

endpackage : decoder_pkg

// File: rtl/decoder_2to4.sv
// Combinational 2-to-4 one-hot decoder; a low enable forces all zeros.
module decoder_2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] out
);

    always_comb begin
        // NOTE: default first so every path assigns out and no latch is inferred.
        out = 4'b0000;
        if (en) begin
            out[sel] = 1'b1;
        end
    end

endmodule : decoder_2to4

// File: rtl/decoder_4to16_reg.sv
// Registered 4-to-16 one-hot decoder built from a two-level tree of 2-to-4 decoders.
module decoder_4to16_reg
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = DEC_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);

    logic        fire;
    logic [3:0]  group_en;
    dec_onehot_t decoded;

    // Gating the root decoder zeroes the whole tree when the input is not taken.
    assign fire = en & in_valid;

    decoder_2to4 u_group (
        .sel (in[3:2]),
        .en  (fire),
        .out (group_en)
    );

    for (genvar g = 0; g < 4; g++) begin : g_line
        decoder_2to4 u_line (
            .sel (in[1:0]),
            .en  (group_en[g]),
            .out (decoded[g*4 +: 4])
        );
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update on the same edge.
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= decoded;
            out_valid <= fire;
        end
    end

endmodule : decoder_4to16_reg

// File: tb/tb_decoder_4to16_reg.sv
// Directed and random checks for decoder_4to16_reg.
module tb_decoder_4to16_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [3:0]  in;
    logic [15:0] out;
    logic        out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    decoder_4to16_reg dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  gap_in    [3] = '{4'd3, 4'd9, 4'd12};
    logic        gap_vld   [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] gap_out   [3] = '{16'h0008, 16'h0000, 16'h1000};

    initial begin
        logic [15:0] exp_out;
        logic        exp_vld;
        logic [15:0] held;

        // Reset dominates an otherwise valid decode.
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; in = 4'hF;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("reset_out_%0d", i), {16'h0, out}, 32'h0);
            check($sformatf("reset_vld_%0d", i), {31'h0, out_valid}, 32'h0);
        end
        rst = 1'b0;

        // Full sweep, back-to-back codes.
        for (int i = 0; i < 16; i++) begin
            in = 4'(i);
            step();
            check($sformatf("sweep_out_%0d", i), {16'h0, out}, {16'h0, 16'h0001 << i});
            check($sformatf("sweep_vld_%0d", i), {31'h0, out_valid}, 32'h1);
            check($sformatf("sweep_pop_%0d", i), $countones(out), 32'd1);
        end

        // Enable low clears, then enable high decodes.
        in = 4'h5; in_valid = 1'b1; en = 1'b0;
        step();
        check("en_low_out", {16'h0, out}, 32'h0);
        check("en_low_vld", {31'h0, out_valid}, 32'h0);
        en = 1'b1;
        step();
        check("en_high_out", {16'h0, out}, 32'h0000_0020);
        check("en_high_vld", {31'h0, out_valid}, 32'h1);

        // Gaps in in_valid clear the output.
        for (int i = 0; i < 3; i++) begin
            in = gap_in[i]; in_valid = gap_vld[i];
            step();
            check($sformatf("gap_out_%0d", i), {16'h0, out}, {16'h0, gap_out[i]});
            check($sformatf("gap_vld_%0d", i), {31'h0, out_valid}, {31'h0, gap_vld[i]});
        end
        in_valid = 1'b1;

        // Reset in the middle of a stream discards the captured code.
        in = 4'd7;
        step();
        check("mid_rst_out0", {16'h0, out}, 32'h0000_0080);
        check("mid_rst_vld0", {31'h0, out_valid}, 32'h1);
        in = 4'd8; rst = 1'b1;
        step();
        check("mid_rst_out1", {16'h0, out}, 32'h0);
        check("mid_rst_vld1", {31'h0, out_valid}, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_out", {16'h0, out}, 32'h0000_0100);
        check("post_rst_vld", {31'h0, out_valid}, 32'h1);

        // Repeated code holds steady; an input change between edges must not reach out.
        step();
        check("repeat_out", {16'h0, out}, 32'h0000_0100);
        check("repeat_vld", {31'h0, out_valid}, 32'h1);
        held = out;
        in = 4'd2; en = 1'b0;
        #2;
        check("no_comb_path", {16'h0, out}, {16'h0, held});

        // Random traffic against the reference model, one cycle of latency.
        for (int i = 0; i < 1000; i++) begin
            in       = 4'($urandom_range(0, 15));
            en       = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            exp_vld  = en & in_valid;
            exp_out  = (16'h0001 << in) & {16{exp_vld}};
            step();
            check($sformatf("rand_out_%0d", i), {16'h0, out}, {16'h0, exp_out});
            check($sformatf("rand_vld_%0d", i), {31'h0, out_valid}, {31'h0, exp_vld});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_decoder_4to16_reg
